// File: rtl/corescore_pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
// Holds the sequencer state encoding and the lock-loss counter width.
package corescore_pll_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/corescore_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module corescore_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: flops are written with <= so both stages sample the pre-edge values; = here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/corescore_pll_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock, retries, and gates the downstream reset.
// Define CORESCORE_PLL_SEQ_LOSS_CNT_EN to implement the saturating lock-loss counter; otherwise it reads 0.
module corescore_pll_seq
  import corescore_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pll_locked,
  input  logic                  i_pwrdwn_req,
  output logic                  o_pll_rst,
  output logic                  o_pll_pwrdwn,
  output logic                  o_rst,
  output logic                  o_ready,
  output logic                  o_fail,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt
);

  localparam int RST_W = cnt_width(RST_CYCLES);
  localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W = cnt_width(STABLE_CYCLES);
  localparam int RTY_W = cnt_width(MAX_RETRIES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  logic lock_s;

  state_e             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               pll_rst_q, pll_pwrdwn_q, rst_q, ready_q, fail_q;

  corescore_sync2 u_lock_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d_i   (i_pll_locked),
    .q_o   (lock_s)
  );

  always_comb begin
    // NOTE: every _d takes its held value first so no branch leaves one unassigned (no latch).
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;

    // A power-down request outranks every other transition except the terminal FAIL.
    if (i_pwrdwn_req && (state_q != ST_FAIL)) begin
      state_d = ST_PWRDN;
    end else begin
      unique case (state_q)
        ST_PWRDN: begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end
        ST_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d   = ST_STABLE;
            stb_cnt_d = '0;
          end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            if (retry_q < RTY_MAX) begin
              state_d   = ST_RESET;
              rst_cnt_d = '0;
              retry_d   = retry_q + RTY_W'(1);
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d   = ST_WAIT_LOCK;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d   = ST_RUN;
            stb_cnt_d = '0;
          end else begin
            stb_cnt_d = stb_cnt_q + STB_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
            retry_d   = '0;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      stb_cnt_q    <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      pll_pwrdwn_q <= 1'b0;
      rst_q        <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == ST_RESET) || (state_d == ST_PWRDN) || (state_d == ST_FAIL);
      pll_pwrdwn_q <= (state_d == ST_PWRDN);
      rst_q        <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  assign o_pll_rst    = pll_rst_q;
  assign o_pll_pwrdwn = pll_pwrdwn_q;
  assign o_rst        = rst_q;
  assign o_ready      = ready_q;
  assign o_fail       = fail_q;

`ifdef CORESCORE_PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  // A lock loss is a RUN-to-RESET transition; power-down exits are not losses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_RESET)) begin
      loss_cnt_q <= sat_inc(loss_cnt_q);
    end
  end

  assign o_lock_loss_cnt = loss_cnt_q;
`else
  assign o_lock_loss_cnt = '0;
`endif

endmodule
